// File: rtl/accel_seq.sv
// Job sequencer: issues LEN item requests, counts completions, reports status and irq.
// Optional ACCEL_SEQ_PERF_EN adds a busy-cycle counter shown in status word0[31:16].
module accel_seq #(
  parameter int DATA_WIDTH   = 32,
  parameter int N_CTRL_WORDS = 2,
  parameter int N_STAT_WORDS = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                     clk,
  input  logic                                     arst,
  input  logic [N_CTRL_WORDS-1:0][DATA_WIDTH-1:0]  ctrl_vec,
  output logic [N_STAT_WORDS-1:0][DATA_WIDTH-1:0]  stat_vec,
  output logic                                     stat_en,
  output logic                                     req_valid,
  input  logic                                     req_ready,
  output logic [CNT_WIDTH-1:0]                     req_idx,
  output logic                                     req_last,
  input  logic                                     rsp_valid,
  input  logic                                     rsp_err,
  output logic                                     irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic [CNT_WIDTH-1:0] lim);
    return (v >= lim) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t                                     r_state;
  logic                                       r_start_q;
  logic [CNT_WIDTH-1:0]                       r_len;
  logic [CNT_WIDTH-1:0]                       r_issued;
  logic [CNT_WIDTH-1:0]                       r_completed;
  logic                                       r_done;
  logic                                       r_err;
  logic                                       r_aborted;
  logic                                       r_req_valid;
  logic                                       r_req_last;
  logic                                       r_irq;
  logic [N_STAT_WORDS-1:0][DATA_WIDTH-1:0]    r_stat;
  logic                                       r_stat_en;
`ifdef ACCEL_SEQ_PERF_EN
  logic [CNT_WIDTH-1:0]                       r_cyc;
`endif

  logic                                       w_start_edge;
  logic                                       w_irq_en;
  logic                                       w_abort;
  logic [CNT_WIDTH-1:0]                       w_len;
  logic                                       w_hs;
  logic                                       w_busy;
  logic [CNT_WIDTH-1:0]                       w_cmp_nxt;
  logic [CNT_WIDTH-1:0]                       w_idx_nxt;
  logic [N_STAT_WORDS-1:0][DATA_WIDTH-1:0]    w_stat_nxt;
  logic                                       w_unused;

  assign w_start_edge = ctrl_vec[0][0] & ~r_start_q;
  assign w_irq_en     = ctrl_vec[0][1];
  assign w_abort      = ctrl_vec[0][2];
  assign w_len        = ctrl_vec[1][CNT_WIDTH-1:0];
  assign w_hs         = r_req_valid & req_ready;
  assign w_busy       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_cmp_nxt    = rsp_valid ? sat_inc(r_completed, r_len) : r_completed;
  assign w_idx_nxt    = r_issued + CNT_WIDTH'(1);
  assign w_unused     = ^ctrl_vec;

  // Status is built from the current registers and presented one cycle later.
  always_comb begin
    w_stat_nxt       = '0;
    w_stat_nxt[0][0] = w_busy;
    w_stat_nxt[0][1] = r_done;
    w_stat_nxt[0][2] = r_err;
    w_stat_nxt[0][3] = r_aborted;
    w_stat_nxt[0][5:4] = r_state;
`ifdef ACCEL_SEQ_PERF_EN
    w_stat_nxt[0][31:16] = 16'(r_cyc);
`endif
    w_stat_nxt[1] = DATA_WIDTH'(r_completed);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= S_IDLE;
      r_start_q   <= 1'b0;
      r_len       <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_aborted   <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_last  <= 1'b0;
      r_irq       <= 1'b0;
      r_stat      <= '0;
      r_stat_en   <= 1'b0;
`ifdef ACCEL_SEQ_PERF_EN
      r_cyc       <= '0;
`endif
    end else begin
      r_start_q <= ctrl_vec[0][0];
      r_irq     <= 1'b0;
      r_stat    <= w_stat_nxt;
      r_stat_en <= (w_stat_nxt != r_stat);
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_len       <= w_len;
            r_issued    <= '0;
            r_completed <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_aborted   <= 1'b0;
`ifdef ACCEL_SEQ_PERF_EN
            r_cyc       <= '0;
`endif
            if (w_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_irq   <= w_irq_en;
            end else begin
              r_state     <= S_ISSUE;
              r_req_valid <= 1'b1;
              r_req_last  <= (w_len == CNT_WIDTH'(1));
            end
          end
        end
        S_ISSUE, S_DRAIN: begin
          // Abort wins over any handshake or completion seen in the same cycle.
          if (w_abort) begin
            r_state     <= S_IDLE;
            r_aborted   <= 1'b1;
            r_req_valid <= 1'b0;
            r_req_last  <= 1'b0;
          end else begin
            r_completed <= w_cmp_nxt;
            if (rsp_valid && rsp_err) r_err <= 1'b1;
            if (r_state == S_ISSUE) begin
              if (w_hs) begin
                r_issued   <= w_idx_nxt;
                r_req_last <= (w_idx_nxt == r_len - CNT_WIDTH'(1));
                if (r_req_last) begin
                  r_state     <= S_DRAIN;
                  r_req_valid <= 1'b0;
                  r_req_last  <= 1'b0;
                end
              end
            end else if (w_cmp_nxt == r_len) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_irq   <= w_irq_en;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
`ifdef ACCEL_SEQ_PERF_EN
      if (w_busy) r_cyc <= sat_inc(r_cyc, '1);
`endif
    end
  end

  assign stat_vec  = r_stat;
  assign stat_en   = r_stat_en;
  assign req_valid = r_req_valid;
  assign req_idx   = r_issued;
  assign req_last  = r_req_last;
  assign irq       = r_irq;

endmodule

// File: tb/tb_accel_seq.sv
// Directed bench for accel_seq: cycle table for LEN=4 / LEN=0, plus stall, abort,
// held-START and mid-job reset sequences.
module tb_accel_seq;

`ifdef ACCEL_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              arst;
  logic [1:0][31:0]  ctrl;
  logic [1:0][31:0]  stat;
  logic              stat_en;
  logic              req_valid;
  logic              req_ready;
  logic [15:0]       req_idx;
  logic              req_last;
  logic              rsp_valid;
  logic              rsp_err;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  accel_seq dut (
    .clk       (clk),
    .arst      (arst),
    .ctrl_vec  (ctrl),
    .stat_vec  (stat),
    .stat_en   (stat_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, ie, ab;
    int   len;
    logic rdy, rv, re;
    logic v;
    int   idx;
    logic last, irq, sen, senp;
    int   w0, w1, cyc;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic st, input logic ie, input logic ab, input int len);
    ctrl[0] = {29'd0, ab, ie, st};
    ctrl[1] = 32'(len);
  endtask

  // Called in the first ISSUE cycle; ready held high, each item answered the cycle after its handshake.
  task automatic run_job(input int len);
    int   n_hs    = 0;
    logic hs_prev = 1'b0;
    bit   got_irq = 1'b0;
    req_ready = 1'b1;
    for (int c = 0; c < 4 * len + 20 && !got_irq; c++) begin
      rsp_valid = hs_prev;
      rsp_err   = 1'b0;
      hs_prev   = 1'b0;
      if (c == 1) begin
        check("job_start_w0", 32'(stat[0][3:0]), 32'h1);
        check("job_start_w1", stat[1], 32'd0);
      end
      if (irq) got_irq = 1'b1;
      if (req_valid) begin
        check("job_idx", 32'(req_idx), 32'(n_hs));
        check("job_last", 32'(req_last), 32'(n_hs == len - 1));
        n_hs++;
        hs_prev = 1'b1;
      end
      tick();
    end
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    check("job_irq_seen", 32'(got_irq), 32'd1);
    check("job_hs_count", 32'(n_hs), 32'(len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_hs;
    int   hs_time [3];
    int   last_rsp;
    int   irq_at;
    logic prev_stall;
    logic [15:0] prev_idx;
    logic rv, re;
    logic [31:0] ew0;

    //                st ie ab len rdy rv re  v idx last irq sen senp  w0     w1 cyc
    vecs[0]  = '{1'b1,1'b1,1'b0,4, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b0,1'b0, 'h00,0,0};
    vecs[1]  = '{1'b1,1'b1,1'b0,4, 1'b1,1'b0,1'b0, 1'b1,0,1'b0,1'b0,1'b0,1'b0, 'h00,0,0};
    vecs[2]  = '{1'b1,1'b1,1'b0,4, 1'b1,1'b1,1'b0, 1'b1,1,1'b0,1'b0,1'b1,1'b1, 'h11,0,0};
    vecs[3]  = '{1'b1,1'b1,1'b0,4, 1'b1,1'b1,1'b0, 1'b1,2,1'b0,1'b0,1'b0,1'b1, 'h11,0,1};
    vecs[4]  = '{1'b1,1'b1,1'b0,4, 1'b1,1'b1,1'b0, 1'b1,3,1'b1,1'b0,1'b1,1'b1, 'h11,1,2};
    vecs[5]  = '{1'b1,1'b1,1'b0,4, 1'b1,1'b1,1'b0, 1'b0,0,1'b0,1'b0,1'b1,1'b1, 'h11,2,3};
    vecs[6]  = '{1'b1,1'b1,1'b0,4, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b1,1'b1,1'b1, 'h21,3,4};
    vecs[7]  = '{1'b0,1'b1,1'b0,4, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b1,1'b1, 'h32,4,5};
    vecs[8]  = '{1'b0,1'b1,1'b0,4, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b1,1'b1, 'h02,4,5};
    vecs[9]  = '{1'b0,1'b1,1'b0,4, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b0,1'b0, 'h02,4,5};
    vecs[10] = '{1'b1,1'b1,1'b0,0, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b0,1'b0, 'h02,4,5};
    vecs[11] = '{1'b1,1'b1,1'b0,0, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b1,1'b0,1'b0, 'h02,4,5};
    vecs[12] = '{1'b0,1'b1,1'b0,0, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b1,1'b1, 'h32,0,0};
    vecs[13] = '{1'b0,1'b1,1'b0,0, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b1,1'b1, 'h02,0,0};
    vecs[14] = '{1'b0,1'b1,1'b0,0, 1'b0,1'b0,1'b0, 1'b0,0,1'b0,1'b0,1'b0,1'b0, 'h02,0,0};

    arst = 1'b1;
    set_ctrl(1'b0, 1'b0, 1'b0, 0);
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_stat0", stat[0], 32'd0);
    check("rst_stat1", stat[1], 32'd0);
    check("rst_outs", {27'd0, stat_en, req_valid, req_last, irq, 1'b0}, 32'd0);
    check("rst_idx", 32'(req_idx), 32'd0);
    arst = 1'b0;
    repeat (2) begin
      tick();
      check("post_rst_stat_en", 32'(stat_en), 32'd0);
      check("post_rst_stat0", stat[0], 32'd0);
    end

    // LEN=4 single-rate job followed by a LEN=0 job.
    for (int i = 0; i < 15; i++) begin
      set_ctrl(vecs[i].st, vecs[i].ie, vecs[i].ab, vecs[i].len);
      req_ready = vecs[i].rdy;
      rsp_valid = vecs[i].rv;
      rsp_err   = vecs[i].re;
      ew0 = {(PERF_ON ? 16'(vecs[i].cyc) : 16'h0), 16'(vecs[i].w0)};
      check($sformatf("vec%0d_valid", i), 32'(req_valid), 32'(vecs[i].v));
      if (vecs[i].v) begin
        check($sformatf("vec%0d_idx", i), 32'(req_idx), 32'(vecs[i].idx));
        check($sformatf("vec%0d_last", i), 32'(req_last), 32'(vecs[i].last));
      end
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].irq));
      check($sformatf("vec%0d_stat_en", i), 32'(stat_en),
            32'(PERF_ON ? vecs[i].senp : vecs[i].sen));
      check($sformatf("vec%0d_w0", i), stat[0], ew0);
      check($sformatf("vec%0d_w1", i), stat[1], 32'(vecs[i].w1));
      tick();
    end

    // LEN=3, ready toggling, responses 5 cycles after each handshake, second one errored.
    req_ready = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b0, 3);
    tick();
    set_ctrl(1'b0, 1'b1, 1'b0, 3);
    n_hs = 0; last_rsp = -1; irq_at = -1; prev_stall = 1'b0; prev_idx = '0;
    for (int c = 1; c <= 80 && irq_at < 0; c++) begin
      req_ready = (c % 2 == 1);
      rv = 1'b0; re = 1'b0;
      for (int k = 0; k < n_hs; k++) begin
        if (hs_time[k] + 5 == c) begin
          rv = 1'b1; re = (k == 1); last_rsp = c;
        end
      end
      rsp_valid = rv;
      rsp_err   = re;
      if (irq) begin
        irq_at = c;
        check("len3_drain_w0", 32'(stat[0][15:0]), 32'h25);
        check("len3_drain_w1", stat[1], 32'd2);
      end
      if (req_valid) begin
        if (prev_stall) check("len3_stall_idx", 32'(req_idx), 32'(prev_idx));
        if (req_ready) begin
          check("len3_idx", 32'(req_idx), 32'(n_hs));
          check("len3_last", 32'(req_last), 32'(n_hs == 2));
          if (n_hs < 3) hs_time[n_hs] = c;
          n_hs++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_idx   = req_idx;
        end
      end else begin
        prev_stall = 1'b0;
      end
      tick();
    end
    rsp_valid = 1'b0; rsp_err = 1'b0; req_ready = 1'b0;
    check("len3_irq_seen", 32'(irq_at > 0), 32'd1);
    check("len3_irq_latency", 32'(irq_at - last_rsp), 32'd1);
    check("len3_hs_count", 32'(n_hs), 32'd3);
    check("len3_done_w0", 32'(stat[0][15:0]), 32'h36);
    tick();
    check("len3_final_w0", 32'(stat[0][15:0]), 32'h06);
    check("len3_final_w1", stat[1], 32'd3);

    // LEN=100 aborted after 10 handshakes.
    req_ready = 1'b1;
    set_ctrl(1'b1, 1'b1, 1'b0, 100);
    tick();
    set_ctrl(1'b0, 1'b1, 1'b0, 100);
    for (int h = 0; h < 10; h++) begin
      check("abort_valid", 32'(req_valid), 32'd1);
      check("abort_idx", 32'(req_idx), 32'(h));
      tick();
    end
    set_ctrl(1'b0, 1'b1, 1'b1, 100);
    check("abort_cycle_valid", 32'(req_valid), 32'd1);
    check("abort_cycle_idx", 32'(req_idx), 32'd10);
    tick();
    set_ctrl(1'b0, 1'b1, 1'b0, 100);
    check("abort_valid_drop", 32'(req_valid), 32'd0);
    check("abort_irq", 32'(irq), 32'd0);
    tick();
    check("abort_w0", 32'(stat[0][15:0]), 32'h08);
    check("abort_w1", stat[1], 32'd0);
    check("abort_stat_en", 32'(stat_en), 32'd1);
    check("abort_cyc", 32'(stat[0][31:16]), PERF_ON ? 32'd11 : 32'd0);
    repeat (5) begin
      tick();
      check("abort_no_irq", 32'(irq), 32'd0);
      check("abort_idle_valid", 32'(req_valid), 32'd0);
    end

    // Restart with START then held high across the whole job.
    set_ctrl(1'b1, 1'b1, 1'b0, 3);
    tick();
    run_job(3);
    tick();
    check("restart_w0", 32'(stat[0][15:0]), 32'h02);
    check("restart_w1", stat[1], 32'd3);
    set_ctrl(1'b1, 1'b1, 1'b0, 2);
    repeat (10) begin
      tick();
      check("held_no_job", 32'(req_valid), 32'd0);
      check("held_idle_w0", 32'(stat[0][15:0]), 32'h02);
      check("held_stat_en", 32'(stat_en), 32'd0);
    end
    set_ctrl(1'b0, 1'b1, 1'b0, 2);
    tick();
    set_ctrl(1'b1, 1'b1, 1'b0, 2);
    tick();
    set_ctrl(1'b0, 1'b1, 1'b0, 2);
    run_job(2);
    tick();
    check("len2_w0", 32'(stat[0][15:0]), 32'h02);
    check("len2_w1", stat[1], 32'd2);

    // Reset in the middle of a job.
    req_ready = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b0, 5);
    tick();
    set_ctrl(1'b0, 1'b1, 1'b0, 5);
    check("midrst_valid_before", 32'(req_valid), 32'd1);
    tick();
    arst = 1'b1;
    #1;
    check("midrst_valid", 32'(req_valid), 32'd0);
    check("midrst_stat0", stat[0], 32'd0);
    check("midrst_stat1", stat[1], 32'd0);
    tick();
    arst = 1'b0;
    repeat (4) begin
      tick();
      check("midrst_no_irq", 32'(irq), 32'd0);
      check("midrst_no_stat_en", 32'(stat_en), 32'd0);
      check("midrst_idle", 32'(req_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
